// File: rtl/ddr_dummy_pkg.sv
// Shared definitions for the DDR dummy responder.
// Contents: address/line widths, responder FSM state type, and the line pattern
// returned when a read address has never been written.
package ddr_dummy_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 256;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    // Miss data: the zero-extended address repeated across the line, so a
    // read of unwritten memory is still recognisable in waveforms.
    function automatic logic [LINE_W-1:0] miss_pattern(input logic [ADDR_W-1:0] addr);
        return {8{4'h0, addr}};
    endfunction

endpackage

// File: rtl/assoc_line_store.sv
// Fully-associative line store keyed by full line address.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears valids/count)
//   i_addr        - lookup address, also the write address
//   i_wr_en       - commit i_wr_data for i_addr this edge
//   i_wr_data     - write line
//   o_hit         - i_addr matches a valid entry
//   o_rd_data     - data of the matching entry (don't-care on miss)
//   o_full        - every entry allocated; a write miss will be dropped
module assoc_line_store
    import ddr_dummy_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_en,
    input  logic [LINE_W-1:0] i_wr_data,
    output logic              o_hit,
    output logic [LINE_W-1:0] o_rd_data,
    output logic              o_full
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [IDX_W-1:0]  w_alloc_idx;

    // Entries are only allocated on a miss, so at most one can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == i_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Entries fill in order and never free, so the count is the next free slot.
    assign w_alloc_idx = r_count[IDX_W-1:0];
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_hit       = w_hit;
    assign o_rd_data   = r_data[w_hit_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (i_wr_en) begin
            if (w_hit) begin
                r_data[w_hit_idx] <= i_wr_data;
            end else if (!o_full) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_addr[w_alloc_idx]  <= i_addr;
                r_data[w_alloc_idx]  <= i_wr_data;
                r_count              <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_dummy_responder.sv
// Behavioural memory-side responder standing in for the DDR2 controller.
// Accepts one command at a time, waits a fixed latency, pulses ready and (for
// reads) returns line data from a small associative store.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_mem_valid       - command valid
//   i_mem_rw          - 1 = write, 0 = read
//   i_mem_addr        - line address
//   i_mem_data_wr     - write line
//   o_mem_ready       - one-cycle response pulse
//   o_mem_data_rd     - read line, valid with o_mem_ready on reads, else holds
//   o_overflow        - sticky: write miss found the store full
//   o_protocol_err    - sticky: command inputs changed while pending
module ddr_dummy_responder
    import ddr_dummy_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_valid,
    input  logic              i_mem_rw,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [LINE_W-1:0] i_mem_data_wr,
    output logic              o_mem_ready,
    output logic [LINE_W-1:0] o_mem_data_rd,
    output logic              o_overflow,
    output logic              o_protocol_err
);

    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [LAT_W-1:0]  w_lat_cnt_next;
    logic [LAT_W-1:0]  w_lat;
    logic              w_accept;
    logic              w_mismatch;

    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              r_ready;
    logic [LINE_W-1:0] r_data_rd;
    logic              r_overflow;
    logic              r_protocol_err;

    logic              w_cmd_rw;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_store_hit;
    logic [LINE_W-1:0] w_store_data;
    logic              w_store_full;
    logic              w_store_wr;

    // In IDLE the live inputs are the command (latency-1 reads go straight to
    // RESP and need lookup before the latch is loaded); otherwise use the latch.
    assign w_cmd_rw   = (r_state == StIdle) ? i_mem_rw   : r_rw;
    assign w_cmd_addr = (r_state == StIdle) ? i_mem_addr : r_addr;
    assign w_lat      = i_mem_rw ? LAT_W'(WR_LATENCY) : LAT_W'(RD_LATENCY);
    assign w_store_wr = (r_state == StResp) && r_rw;

    assoc_line_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (w_cmd_addr),
        .i_wr_en   (w_store_wr),
        .i_wr_data (r_wdata),
        .o_hit     (w_store_hit),
        .o_rd_data (w_store_data),
        .o_full    (w_store_full)
    );

    always_comb begin
        w_state_next   = r_state;
        w_lat_cnt_next = r_lat_cnt;
        w_accept       = 1'b0;
        w_mismatch     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_mem_valid) begin
                    w_accept = 1'b1;
                    if (w_lat == LAT_W'(1)) begin
                        w_state_next = StResp;
                    end else begin
                        w_state_next   = StWait;
                        w_lat_cnt_next = w_lat - LAT_W'(1);
                    end
                end
            end
            StWait: begin
                w_mismatch = !i_mem_valid || (i_mem_rw != r_rw) ||
                             (i_mem_addr != r_addr) || (i_mem_data_wr != r_wdata);
                w_lat_cnt_next = r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_lat_cnt      <= '0;
            r_rw           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_ready        <= 1'b0;
            r_data_rd      <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lat_cnt <= w_lat_cnt_next;
            if (w_accept) begin
                r_rw    <= i_mem_rw;
                r_addr  <= i_mem_addr;
                r_wdata <= i_mem_data_wr;
            end
            // Ready and read data are registered on entry to RESP so both
            // are presented together during the RESP cycle.
            r_ready <= (w_state_next == StResp);
            if ((w_state_next == StResp) && !w_cmd_rw) begin
                r_data_rd <= w_store_hit ? w_store_data : miss_pattern(w_cmd_addr);
            end
            if (w_mismatch) begin
                r_protocol_err <= 1'b1;
            end
            if (w_store_wr && !w_store_hit && w_store_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_mem_ready    = r_ready;
    assign o_mem_data_rd  = r_data_rd;
    assign o_overflow     = r_overflow;
    assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_ddr_dummy_responder.sv
module tb_ddr_dummy_responder;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_valid = 1'b0;
    logic         mem_rw = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [255:0] mem_data_wr = '0;
    logic         mem_ready;
    logic [255:0] mem_data_rd;
    logic         overflow;
    logic         protocol_err;

    always #5 clk = ~clk;

    ddr_dummy_responder #(
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_valid    (mem_valid),
        .i_mem_rw       (mem_rw),
        .i_mem_addr     (mem_addr),
        .i_mem_data_wr  (mem_data_wr),
        .o_mem_ready    (mem_ready),
        .o_mem_data_rd  (mem_data_rd),
        .o_overflow     (overflow),
        .o_protocol_err (protocol_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an address-keyed map plus the single outstanding command.
    logic [255:0] m_mem [logic [27:0]];
    bit           m_pend = 1'b0;
    int           m_ready_at = 0;
    logic         m_rw = 1'b0;
    logic [27:0]  m_addr = '0;
    logic [255:0] m_wdata = '0;
    logic [255:0] m_rd_last = '0;
    bit           m_ovf = 1'b0;
    int           m_perr_from = 32'h7fffffff;

    logic [27:0]  pool [6];

    function automatic logic [255:0] miss_line(input logic [27:0] a);
        return {8{4'h0, a}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mem.delete();
        m_pend      = 1'b0;
        m_ovf       = 1'b0;
        m_perr_from = 32'h7fffffff;
        m_rd_last   = '0;
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin : cmp
        bit exp_ready;
        if (!rst) begin
            exp_ready = m_pend && (cyc == m_ready_at);
            if (exp_ready && !m_rw) begin
                m_rd_last = m_mem.exists(m_addr) ? m_mem[m_addr] : miss_line(m_addr);
            end
            check("mem_ready", 256'(mem_ready), 256'(exp_ready));
            check("mem_data_rd", mem_data_rd, m_rd_last);
            check("overflow", 256'(overflow), 256'(m_ovf));
            check("protocol_err", 256'(protocol_err), 256'(cyc >= m_perr_from));
            if (exp_ready) begin
                if (m_rw) begin
                    if (m_mem.exists(m_addr) || (m_mem.num() < DEPTH)) m_mem[m_addr] = m_wdata;
                    else m_ovf = 1'b1;
                end
                m_pend = 1'b0;
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_valid = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b0;
    endtask

    // corrupt: 0 none, 1 addr bit, 2 rw, 3 drop valid, 4 data bit.
    // abort: assert reset while the command is waiting.
    task automatic do_cmd(input logic rw, input logic [27:0] addr, input logic [255:0] data,
                          input int corrupt, input bit abort);
        int lat;
        int a;
        int kk;
        int b;
        lat         = rw ? WR_LAT : RD_LAT;
        mem_valid   = 1'b1;
        mem_rw      = rw;
        mem_addr    = addr;
        mem_data_wr = data;
        a           = cyc + 1;
        m_pend      = 1'b1;
        m_ready_at  = a + lat - 1;
        m_rw        = rw;
        m_addr      = addr;
        m_wdata     = data;
        kk          = int'($urandom_range(lat - 2, 0));
        if (abort) begin
            idle(1);
            rst       = 1'b1;
            mem_valid = 1'b0;
            model_reset();
            idle(2);
            rst = 1'b0;
            return;
        end
        for (int i = 0; i <= lat; i++) begin
            idle(1);
            if ((corrupt != 0) && (i == kk)) begin
                case (corrupt)
                    1: begin
                        b = int'($urandom_range(27, 0));
                        mem_addr[b] = ~mem_addr[b];
                    end
                    2: mem_rw = ~mem_rw;
                    3: mem_valid = 1'b0;
                    default: begin
                        b = int'($urandom_range(255, 0));
                        mem_data_wr[b] = ~mem_data_wr[b];
                    end
                endcase
                if (cyc + 1 < m_perr_from) m_perr_from = cyc + 1;
            end
        end
        mem_valid   = 1'b0;
        mem_rw      = 1'($urandom);
        mem_addr    = 28'($urandom);
        mem_data_wr = {8{$urandom}};
    endtask

    localparam logic [255:0] W1 =
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

    initial begin
        logic [255:0] d;
        do_reset();
        check("reset ready", 256'(mem_ready), 256'(0));
        check("reset data", mem_data_rd, 256'(0));
        check("reset overflow", 256'(overflow), 256'(0));
        check("reset protocol_err", 256'(protocol_err), 256'(0));

        // Write then read back, each latency checked cycle-exactly by cmp.
        do_cmd(1'b1, 28'h0000008, W1, 0, 1'b0);
        do_cmd(1'b0, 28'h0000008, '0, 0, 1'b0);
        check("read after write", mem_data_rd, W1);

        do_cmd(1'b0, 28'h2000030, '0, 0, 1'b0);
        check("miss pattern", mem_data_rd,
              256'h02000030_02000030_02000030_02000030_02000030_02000030_02000030_02000030);
        check("miss no overflow", 256'(overflow), 256'(0));

        // Rewriting one address must use a single entry.
        do_reset();
        do_cmd(1'b1, 28'h1300000, {8{32'hAAAA0001}}, 0, 1'b0);
        do_cmd(1'b1, 28'h1300000, {8{32'hBBBB0002}}, 0, 1'b0);
        do_cmd(0, 28'h1300000, '0, 0, 1'b0);
        check("overwrite", mem_data_rd, {8{32'hBBBB0002}});
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 28'h0500000 + 28'(i), {8{32'(i)}}, 0, 1'b0);
        check("four entries no overflow", 256'(overflow), 256'(0));

        // Fill a DEPTH-4 store, then one more distinct write overflows.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("overflow before 5th", 256'(overflow), 256'(0));
            do_cmd(1'b1, 28'h0100000 + 28'(i * 16), {8{32'hA0000000 + 32'(i)}}, 0, 1'b0);
        end
        check("overflow after 5th", 256'(overflow), 256'(1));
        do_cmd(1'b0, 28'h0100040, '0, 0, 1'b0);
        check("dropped write reads miss", mem_data_rd, {8{32'h00100040}});
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 28'h0100000 + 28'(i * 16), '0, 0, 1'b0);
            d = {8{32'hA0000000 + 32'(i)}};
            check("first four intact", mem_data_rd, d);
        end

        // Address changed while waiting: flag set, response uses latched address.
        do_cmd(1'b0, 28'h0100010, '0, 1, 1'b0);
        check("latched addr data", mem_data_rd, {8{32'hA0000001}});
        check("protocol_err set", 256'(protocol_err), 256'(1));
        do_cmd(1'b0, 28'h0100000, '0, 0, 1'b0);
        check("protocol_err sticky", 256'(protocol_err), 256'(1));
        check("overflow sticky", 256'(overflow), 256'(1));

        // Reset during a pending write: no ready, no commit, all outputs cleared.
        do_reset();
        do_cmd(1'b1, 28'h0ABCDE0, W1, 0, 1'b1);
        check("abort ready", 256'(mem_ready), 256'(0));
        check("abort data", mem_data_rd, 256'(0));
        check("abort overflow", 256'(overflow), 256'(0));
        check("abort protocol_err", 256'(protocol_err), 256'(0));
        idle(1);
        do_cmd(1'b0, 28'h0ABCDE0, '0, 0, 1'b0);
        check("aborted write not stored", mem_data_rd, {8{32'h00ABCDE0}});

        // Randomised traffic over a small address pool.
        for (int i = 0; i < 6; i++) pool[i] = 28'($urandom);
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [27:0] ad;
            r  = int'($urandom_range(99, 0));
            ad = ($urandom_range(9, 0) == 0) ? 28'($urandom) : pool[$urandom_range(5, 0)];
            if (r < 3) begin
                do_reset();
            end else begin
                do_cmd(1'($urandom), ad, {8{$urandom}},
                       (r >= 90) ? int'($urandom_range(4, 1)) : 0, (r == 3) || (r == 4));
            end
            idle(int'($urandom_range(2, 0)));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_dummy_responder.md
# ddr_dummy_responder

Behavioural memory-side responder for the cache–DDR command interface, used in simulation/FPGA bring-up in place of the DDR2 controller. Accepts one read or write command at a time from a cache (or cache dummy), waits a configurable latency, then pulses `mem_ready` and, for reads, drives the line data. Line storage is a small fully-associative store keyed by the full 28-bit address. Sticky flags report store overflow and initiator protocol violations.

## Interface
- `DEPTH`, 64: number of storable lines (fully associative, 1..64).
- `RD_LATENCY`, 4: cycles from command acceptance to ready for reads (≥1).
- `WR_LATENCY`, 2: same for writes (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_valid` in 1: command valid from initiator.
- `mem_rw` in 1: 1 = write, 0 = read.
- `mem_addr` in 28: line address.
- `mem_data_wr` in 256: write data.
- `mem_ready` out 1: one-cycle response pulse.
- `mem_data_rd` out 256: read data, valid when `mem_ready` is high and the command is a read.
- `overflow` out 1: sticky; a write to a new address found the store full.
- `protocol_err` out 1: sticky; command inputs changed or valid dropped while pending.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `mem_valid`=1, latch rw/addr/wdata, load counter with latency−1 (RD or WR per `mem_rw`), go WAIT; if latency is 1, go directly to RESP.
- WAIT: decrement counter; at 1 go RESP. Each cycle compare live `mem_valid/mem_rw/mem_addr/mem_data_wr` with latched values; any mismatch sets `protocol_err`. Behaviour continues on latched command.
- RESP: `mem_ready`=1 for exactly this cycle; next state IDLE unconditionally (one bubble; no back-to-back acceptance).
- Lookup: combinational match of latched addr against all valid entries; at most one hit by construction.
- Read in RESP: hit → entry data; miss → `{8{4'h0, addr}}`. `mem_data_rd` registered, holds last value between responses.
- Write commits on the RESP clock edge: hit → overwrite data; miss and count<DEPTH → allocate entry[count], count++; miss and count==DEPTH → discard, set `overflow`.
- Reads never allocate. No eviction.

## Timing
- Acceptance at edge E (valid seen in IDLE); `mem_ready` high during cycle E+latency; IDLE at E+latency+1; earliest next acceptance edge E+latency+1.
- Initiator must hold command stable from acceptance through the ready cycle; it may change inputs on the ready edge.
- Reset values: `mem_ready`=0, `mem_data_rd`=0, `overflow`=0, `protocol_err`=0, state IDLE, count=0, all entry valids 0.
- Reset mid-command: pending command dropped, no ready, no write commit, store cleared.
- `mem_valid` low in IDLE: stay IDLE, outputs hold.
- Sticky flags clear only on `rst`.

## Structure
- Package `ddr_dummy_pkg`: `ADDR_W`=28, `LINE_W`=256, FSM state enum, miss-pattern function.
- Sub-module `assoc_line_store`: DEPTH entries of {valid, addr, data}, combinational hit/index/data lookup, write port (update or allocate), full flag, count. Top holds FSM, latency counter, protocol checker, output registers.

## Test plan
- Write 0x0000008 ← 0x1111…8888 (WR_LATENCY=2) → ready exactly 2 cycles after acceptance; read same addr (RD_LATENCY=4) → ready 4 cycles after acceptance with 0x1111…8888.
- Read never-written 0x2000030 → data `{8{32'h02000030}}`, `overflow`=0.
- Write 0x1300000 twice (A then B), read → B; count stays 1.
- DEPTH=4: write 5 distinct addrs → `overflow`=1 after 5th ready; read 5th addr → miss pattern; first four read back correctly.
- Change `mem_addr` during WAIT → `protocol_err`=1, ready still at scheduled cycle with latched-address data; persists until rst.
- Assert rst in WAIT of a write → no ready, subsequent read of that addr returns miss pattern; all outputs 0.
